// File: rtl/zuc_pkg.sv
// ZUC S-box tables, FIFO depth and byte-to-table map shared by the S-box lanes.
package zuc_pkg;

  localparam int FIFO_DEPTH = 3;

  // Bit b selects the table for byte b of a word: 1 = S0, 0 = S1.
  localparam logic [3:0] BYTE_MAP = 4'b1010;

  localparam logic [7:0] S0 [256] = '{
    8'h3e,8'h72,8'h5b,8'h47,8'hca,8'he0,8'h00,8'h33,8'h04,8'hd1,8'h54,8'h98,8'h09,8'hb9,8'h6d,8'hcb,
    8'h7b,8'h1b,8'hf9,8'h32,8'haf,8'h9d,8'h6a,8'ha5,8'hb8,8'h2d,8'hfc,8'h1d,8'h08,8'h53,8'h03,8'h90,
    8'h4d,8'h4e,8'h84,8'h99,8'he4,8'hce,8'hd9,8'h91,8'hdd,8'hb6,8'h85,8'h48,8'h8b,8'h29,8'h6e,8'hac,
    8'hcd,8'hc1,8'hf8,8'h1e,8'h73,8'h43,8'h69,8'hc6,8'hb5,8'hbd,8'hfd,8'h39,8'h63,8'h20,8'hd4,8'h38,
    8'h76,8'h7d,8'hb2,8'ha7,8'hcf,8'hed,8'h57,8'hc5,8'hf3,8'h2c,8'hbb,8'h14,8'h21,8'h06,8'h55,8'h9b,
    8'he3,8'hef,8'h5e,8'h31,8'h4f,8'h7f,8'h5a,8'ha4,8'h0d,8'h82,8'h51,8'h49,8'h5f,8'hba,8'h58,8'h1c,
    8'h4a,8'h16,8'hd5,8'h17,8'ha8,8'h92,8'h24,8'h1f,8'h8c,8'hff,8'hd8,8'hae,8'h2e,8'h01,8'hd3,8'had,
    8'h3b,8'h4b,8'hda,8'h46,8'heb,8'hc9,8'hde,8'h9a,8'h8f,8'h87,8'hd7,8'h3a,8'h80,8'h6f,8'h2f,8'hc8,
    8'hb1,8'hb4,8'h37,8'hf7,8'h0a,8'h22,8'h13,8'h28,8'h7c,8'hcc,8'h3c,8'h89,8'hc7,8'hc3,8'h96,8'h56,
    8'h07,8'hbf,8'h7e,8'hf0,8'h0b,8'h2b,8'h97,8'h52,8'h35,8'h41,8'h79,8'h61,8'ha6,8'h4c,8'h10,8'hfe,
    8'hbc,8'h26,8'h95,8'h88,8'h8a,8'hb0,8'ha3,8'hfb,8'hc0,8'h18,8'h94,8'hf2,8'he1,8'he5,8'he9,8'h5d,
    8'hd0,8'hdc,8'h11,8'h66,8'h64,8'h5c,8'hec,8'h59,8'h42,8'h75,8'h12,8'hf5,8'h74,8'h9c,8'haa,8'h23,
    8'h0e,8'h86,8'hab,8'hbe,8'h2a,8'h02,8'he7,8'h67,8'he6,8'h44,8'ha2,8'h6c,8'hc2,8'h93,8'h9f,8'hf1,
    8'hf6,8'hfa,8'h36,8'hd2,8'h50,8'h68,8'h9e,8'h62,8'h71,8'h15,8'h3d,8'hd6,8'h40,8'hc4,8'he2,8'h0f,
    8'h8e,8'h83,8'h77,8'h6b,8'h25,8'h05,8'h3f,8'h0c,8'h30,8'hea,8'h70,8'hb7,8'ha1,8'he8,8'ha9,8'h65,
    8'h8d,8'h27,8'h1a,8'hdb,8'h81,8'hb3,8'ha0,8'hf4,8'h45,8'h7a,8'h19,8'hdf,8'hee,8'h78,8'h34,8'h60
  };

  localparam logic [7:0] S1 [256] = '{
    8'h55,8'hc2,8'h63,8'h71,8'h3b,8'hc8,8'h47,8'h86,8'h9f,8'h3c,8'hda,8'h5b,8'h29,8'haa,8'hfd,8'h77,
    8'h8c,8'hc5,8'h94,8'h0c,8'ha6,8'h1a,8'h13,8'h00,8'he3,8'ha8,8'h16,8'h72,8'h40,8'hf9,8'hf8,8'h42,
    8'h44,8'h26,8'h68,8'h96,8'h81,8'hd9,8'h45,8'h3e,8'h10,8'h76,8'hc6,8'ha7,8'h8b,8'h39,8'h43,8'he1,
    8'h3a,8'hb5,8'h56,8'h2a,8'hc0,8'h6d,8'hb3,8'h05,8'h22,8'h66,8'hbf,8'hdc,8'h0b,8'hfa,8'h62,8'h48,
    8'hdd,8'h20,8'h11,8'h06,8'h36,8'hc9,8'hc1,8'hcf,8'hf6,8'h27,8'h52,8'hbb,8'h69,8'hf5,8'hd4,8'h87,
    8'h7f,8'h84,8'h4c,8'hd2,8'h9c,8'h57,8'ha4,8'hbc,8'h4f,8'h9a,8'hdf,8'hfe,8'hd6,8'h8d,8'h7a,8'heb,
    8'h2b,8'h53,8'hd8,8'h5c,8'ha1,8'h14,8'h17,8'hfb,8'h23,8'hd5,8'h7d,8'h30,8'h67,8'h73,8'h08,8'h09,
    8'hee,8'hb7,8'h70,8'h3f,8'h61,8'hb2,8'h19,8'h8e,8'h4e,8'he5,8'h4b,8'h93,8'h8f,8'h5d,8'hdb,8'ha9,
    8'had,8'hf1,8'hae,8'h2e,8'hcb,8'h0d,8'hfc,8'hf4,8'h2d,8'h46,8'h6e,8'h1d,8'h97,8'he8,8'hd1,8'he9,
    8'h4d,8'h37,8'ha5,8'h75,8'h5e,8'h83,8'h9e,8'hab,8'h82,8'h9d,8'hb9,8'h1c,8'he0,8'hcd,8'h49,8'h89,
    8'h01,8'hb6,8'hbd,8'h58,8'h24,8'ha2,8'h5f,8'h38,8'h78,8'h99,8'h15,8'h90,8'h50,8'hb8,8'h95,8'he4,
    8'hd0,8'h91,8'hc7,8'hce,8'hed,8'h0f,8'hb4,8'h6f,8'ha0,8'hcc,8'hf0,8'h02,8'h4a,8'h79,8'hc3,8'hde,
    8'ha3,8'hef,8'hea,8'h51,8'he6,8'h6b,8'h18,8'hec,8'h1b,8'h2c,8'h80,8'hf7,8'h74,8'he7,8'hff,8'h21,
    8'h5a,8'h6a,8'h54,8'h1e,8'h41,8'h31,8'h92,8'h35,8'hc4,8'h33,8'h07,8'h0a,8'hba,8'h7e,8'h0e,8'h34,
    8'h88,8'hb1,8'h98,8'h7c,8'hf3,8'h3d,8'h60,8'h6c,8'h7b,8'hca,8'hd3,8'h1f,8'h32,8'h65,8'h04,8'h28,
    8'h64,8'hbe,8'h85,8'h9b,8'h2f,8'h59,8'h8a,8'hd7,8'hb0,8'h25,8'hac,8'haf,8'h12,8'h03,8'he2,8'hf2
  };

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(FIFO_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/zuc_sbox_rom.sv
// Dual-read synchronous 256x8 ZUC S-box ROM; TABLE 0 selects S0, 1 selects S1.
module zuc_sbox_rom #(
  parameter int TABLE     = 0,
  parameter     RAM_STYLE = "distributed"
) (
  input  logic       clk,
  input  logic       en,
  input  logic [7:0] a0,
  input  logic [7:0] a1,
  output logic [7:0] d0,
  output logic [7:0] d1
);
  import zuc_pkg::*;

  (* ram_style = RAM_STYLE *) logic [7:0] rom [256];

  if (TABLE == 0) begin : g_s0
    assign rom = S0;
  end else begin : g_s1
    assign rom = S1;
  end

  // Reads are gated so the outputs only move on an accepted beat.
  always_ff @(posedge clk) begin
    if (en) begin
      d0 <= rom[a0];
      d1 <= rom[a1];
    end
  end

endmodule

// File: rtl/zuc_sbox_lanes.sv
// Multi-lane pipelined ZUC S-box stage: ROM stage then 3-entry FWFT FIFO under credit control.
// Optional ZUC_SBOX_STATS_EN adds a saturating stat_beats counter of delivered beats.
module zuc_sbox_lanes #(
  parameter int LANES     = 2,
  parameter int USER_W    = 1,
  parameter     RAM_STYLE = "distributed"
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [32*LANES-1:0]   s_data,
  input  logic [USER_W-1:0]     s_user,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [32*LANES-1:0]   m_data,
  output logic [USER_W-1:0]     m_user
`ifdef ZUC_SBOX_STATS_EN
  , output logic [31:0]         stat_beats
`endif
);
  import zuc_pkg::*;

  localparam int EW = 32*LANES + USER_W;

  logic                accept;
  logic                v1;
  logic [32*LANES-1:0] data1;
  logic [USER_W-1:0]   user1;
  logic                push;
  logic                pop;
  logic [1:0]          count;
  logic [1:0]          count_n;
  logic [1:0]          wr_ptr;
  logic [1:0]          rd_ptr;
  logic                credit_ok;
  logic [EW-1:0]       mem [FIFO_DEPTH];

  assign accept = s_valid && s_ready;

  // S0 ROM covers bytes 3 and 1, S1 ROM covers bytes 2 and 0 (see BYTE_MAP).
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    zuc_sbox_rom #(.TABLE(0), .RAM_STYLE(RAM_STYLE)) u_s0 (
      .clk (clk),
      .en  (accept),
      .a0  (s_data[32*i+24 +: 8]),
      .a1  (s_data[32*i+8  +: 8]),
      .d0  (data1[32*i+24 +: 8]),
      .d1  (data1[32*i+8  +: 8])
    );
    zuc_sbox_rom #(.TABLE(1), .RAM_STYLE(RAM_STYLE)) u_s1 (
      .clk (clk),
      .en  (accept),
      .a0  (s_data[32*i+16 +: 8]),
      .a1  (s_data[32*i    +: 8]),
      .d0  (data1[32*i+16 +: 8]),
      .d1  (data1[32*i    +: 8])
    );
  end

  assign push    = v1;
  assign m_valid = (count != 2'd0);
  assign pop     = m_valid && m_ready;
  assign {m_data, m_user} = mem[rd_ptr];

  always_comb begin
    count_n = count;
    case ({push, pop})
      2'b10:   count_n = count + 2'd1;
      2'b01:   count_n = count - 2'd1;
      default: count_n = count;
    endcase
  end

  // The beat accepted now lands in the FIFO next cycle, so it already holds a credit.
  assign credit_ok = ({1'b0, count_n} + {2'b00, accept}) < 3'(FIFO_DEPTH);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      v1      <= 1'b0;
      count   <= 2'd0;
      wr_ptr  <= 2'd0;
      rd_ptr  <= 2'd0;
      s_ready <= 1'b0;
    end else begin
      v1      <= accept;
      count   <= count_n;
      s_ready <= credit_ok;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) user1 <= s_user;
    if (push)   mem[wr_ptr] <= {data1, user1};
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      assert (({1'b0, count} + {2'b00, v1}) <= 3'(FIFO_DEPTH));
    end
  end

`ifdef ZUC_SBOX_STATS_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      stat_beats <= 32'd0;
    end else if (pop && (stat_beats != 32'hFFFF_FFFF)) begin
      stat_beats <= stat_beats + 32'd1;
    end
  end
`endif

endmodule
